stage_4: RTL
============

# stage_4

Stage 4 is the final pipeline stage and sits directly after stage 3. It consumes stage 3's registered opcode, soft-error flag, tag-match flag, tagged TX word and RX data, and delivers them to the outside:
- The TX path buffers clean tagged words in a small FIFO and drains them to the network with a valid/ready handshake.
- The RX path presents tag-verified data to the host through a one-entry skid register.
- Optional saturating statistics count dropped, mismatched and overflowed words.

## Interface
Parameters:
- data_size, 32, payload width
- tag_size, 8, tag width
- fifo_depth, 4, TX FIFO entries (power of two, ≥2)
- cnt_size, 16, statistics counter width

Ports:
- clk  in  1  single clock; all state updates on rising edge
- reset  in  1  synchronous, active-high
- opcode_in  in  2  opcode from stage 3: NOP, TX, RX, CLR
- soft_error_in  in  1  soft error detected on the TX word
- tag_match_in  in  1  RX tag matched recomputed tag
- tx_word_in  in  data_size+tag_size  tagged TX word {data, tag}
- rx_data_in  in  data_size  RX payload from stage 3
- net_tx_valid  out  1  FIFO head valid
- net_tx_ready  in  1  network accepts head
- net_tx_data  out  data_size+tag_size  FIFO head word
- host_rx_valid  out  1  RX register holds data
- host_rx_ready  in  1  host accepts RX data
- host_rx_data  out  data_size  RX payload to host
- tx_full  out  1  FIFO full (advisory to control)
- tx_drop_cnt  out  cnt_size  TX words dropped for soft error
- rx_mismatch_cnt  out  cnt_size  RX words with failed tag check
- overflow_cnt  out  cnt_size  words lost to a full FIFO or RX register

## Operation
- Opcode encoding: 2'b00 NOP, 2'b01 TX, 2'b10 RX, 2'b11 CLR.
- TX with soft_error_in=1:
  - Word discarded; tx_drop_cnt increments.
- TX with soft_error_in=0:
  - Word pushed into the FIFO.
  - If the FIFO is full and no pop happens in the same cycle, the word is discarded and overflow_cnt increments.
  - Push and pop in the same cycle on a full FIFO: both occur, no overflow.
- FIFO pop: when net_tx_valid && net_tx_ready.
- FIFO pointers: log2(fifo_depth) bits plus one wrap bit.
  - full = addresses equal and wrap bits differ.
  - empty = pointers equal.
- RX with tag_match_in=0:
  - Data discarded; rx_mismatch_cnt increments.
- RX with tag_match_in=1:
  - Data loaded if the register is empty or being consumed this cycle (host_rx_valid && host_rx_ready).
  - Otherwise the data is discarded, overflow_cnt increments, and the held data is kept.
- CLR: all three counters return to 0. FIFO and RX register are unaffected.
- Counters saturate at all-ones. A counter event in the same cycle as CLR yields 0.
- soft_error_in and tag_match_in are ignored for opcodes they do not apply to.

## Timing
- Reset values:
  - net_tx_valid=0, host_rx_valid=0, tx_full=0, all counters 0.
  - net_tx_data and host_rx_data = 0.
  - FIFO pointers 0.
- Reset mid-operation flushes FIFO contents and the RX register; no handshake completes in the reset cycle.
- TX latency: a word pushed at edge N sees net_tx_valid=1 and net_tx_data=word after edge N, when the FIFO was empty.
- net_tx_data is a combinational read of the head entry. It is stable while net_tx_valid=1 and net_tx_ready=0.
- RX latency: one edge. host_rx_data/host_rx_valid are registered.
- host_rx_data is stable while not accepted.
- tx_full is derived from registered pointers; it has no combinational path from inputs.
- Counters update one edge after their event.

## Configuration
- STAGE_4_STATS_EN defined: the three counters and CLR behaviour are implemented as described.
- STAGE_4_STATS_EN undefined: no counter registers exist, counter outputs are tied to 0, and CLR behaves as NOP. The data paths are identical in both builds.

## Structure
- Shared package asp_pkg holds:
  - opcode localparams OP_NOP, OP_TX, OP_RX, OP_CLR
  - default width constants shared with stages 1–3
- One sub-module, stage_4_tx_fifo, is parameterized by width and depth. It provides push/pop, head data, full and empty, with synchronous reset.
- RX register, opcode decode and counters live in stage_4.

## Test plan
- Reset, then TX of 0x12345678/tag 0xA5 with soft_error=0 and net_tx_ready=0 → net_tx_valid=1 and net_tx_data=0x12345678A5 after one edge, held until ready=1, then valid=0.
- Five clean TX words with net_tx_ready=0 and fifo_depth=4 → tx_full=1 after the 4th, 5th dropped, overflow_cnt=1. Then ready=1 → the four words drain in order.
- Full FIFO with a push and ready=1 in the same cycle → no overflow, occupancy stays 4, order preserved.
- TX with soft_error=1 ×3 → FIFO stays empty, tx_drop_cnt=3. Then CLR → tx_drop_cnt=0.
- RX 0xDEADBEEF with tag_match=1 and host_rx_ready=0, then RX 0x1 with tag_match=1 → host_rx_data stays 0xDEADBEEF, overflow_cnt=1. RX with tag_match=0 → rx_mismatch_cnt=1.
- Counter preloaded near saturation via repeated drops → holds 0xFFFF. Reset asserted mid-drain → all outputs at reset values on the next cycle.

Source files
------------

// File: rtl/asp_pkg.sv
// ---------------------------------------------------------------------------
// asp_pkg: definitions shared by every stage of the pipeline.
//   OP_NOP/OP_TX/OP_RX/OP_CLR : 2-bit opcode encodings carried stage to stage
//   DATA_SIZE/TAG_SIZE        : default payload and tag widths
//   FIFO_DEPTH/CNT_SIZE       : default stage 4 TX FIFO depth, counter width
// ---------------------------------------------------------------------------
package asp_pkg;
  localparam logic [1:0] OP_NOP = 2'b00;
  localparam logic [1:0] OP_TX  = 2'b01;
  localparam logic [1:0] OP_RX  = 2'b10;
  localparam logic [1:0] OP_CLR = 2'b11;

  localparam int DATA_SIZE  = 32;
  localparam int TAG_SIZE   = 8;
  localparam int FIFO_DEPTH = 4;
  localparam int CNT_SIZE   = 16;
endpackage

// File: rtl/stage_4_tx_fifo.sv
// ---------------------------------------------------------------------------
// stage_4_tx_fifo: synchronous FIFO with a combinational head read.
//   clk, reset : clock, synchronous active-high reset (flushes contents)
//   i_push     : write request (ignored when full unless a pop also occurs)
//   i_pop      : read request (ignored when empty)
//   i_data     : word to write
//   o_data     : head entry
//   o_full     : all entries occupied
//   o_empty    : no entries occupied
// ---------------------------------------------------------------------------
module stage_4_tx_fifo #(
  parameter int WIDTH = 40,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_push,
  input  logic             i_pop,
  input  logic [WIDTH-1:0] i_data,
  output logic [WIDTH-1:0] o_data,
  output logic             o_full,
  output logic             o_empty
);
  localparam int AW = $clog2(DEPTH);

  // Pointers carry one extra wrap bit to tell full from empty.
  logic [AW:0]      r_wr_ptr;
  logic [AW:0]      r_rd_ptr;
  logic [WIDTH-1:0] r_mem [DEPTH];

  logic w_do_push;
  logic w_do_pop;

  assign o_empty = (r_wr_ptr == r_rd_ptr);
  assign o_full  = (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]) &&
                   (r_wr_ptr[AW] != r_rd_ptr[AW]);
  assign o_data  = r_mem[r_rd_ptr[AW-1:0]];

  // A push into a full FIFO is allowed when the head leaves in the same cycle.
  assign w_do_pop  = i_pop && !o_empty;
  assign w_do_push = i_push && (!o_full || w_do_pop);

  // Storage and pointer update; reset also clears storage so the head reads 0.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= '0;
      end
    end else begin
      if (w_do_push) begin
        r_mem[r_wr_ptr[AW-1:0]] <= i_data;
        r_wr_ptr <= r_wr_ptr + {{AW{1'b0}}, 1'b1};
      end
      if (w_do_pop) begin
        r_rd_ptr <= r_rd_ptr + {{AW{1'b0}}, 1'b1};
      end
    end
  end
endmodule

// File: rtl/stage_4.sv
// ---------------------------------------------------------------------------
// stage_4: final pipeline stage. Buffers clean TX words for the network,
// presents tag-verified RX data to the host, and optionally keeps statistics.
//   clk, reset        : clock, synchronous active-high reset
//   opcode_in         : NOP/TX/RX/CLR from stage 3
//   soft_error_in     : TX word is corrupt (drop it)
//   tag_match_in      : RX tag verified
//   tx_word_in        : {data, tag} TX word
//   rx_data_in        : RX payload
//   net_tx_*          : valid/ready stream of FIFO head words to the network
//   host_rx_*         : valid/ready RX payload to the host (one-entry register)
//   tx_full           : TX FIFO full
//   tx_drop_cnt       : soft-error TX drops
//   rx_mismatch_cnt   : RX tag-check failures
//   overflow_cnt      : words lost to a full FIFO or occupied RX register
// Build option: define STAGE_4_STATS_EN to implement the saturating counters
// and CLR; otherwise counters read 0 and CLR acts as NOP.
// ---------------------------------------------------------------------------
module stage_4
  import asp_pkg::*;
#(
  parameter int data_size  = DATA_SIZE,
  parameter int tag_size   = TAG_SIZE,
  parameter int fifo_depth = FIFO_DEPTH,
  parameter int cnt_size   = CNT_SIZE
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [1:0]                    opcode_in,
  input  logic                          soft_error_in,
  input  logic                          tag_match_in,
  input  logic [data_size+tag_size-1:0] tx_word_in,
  input  logic [data_size-1:0]          rx_data_in,
  output logic                          net_tx_valid,
  input  logic                          net_tx_ready,
  output logic [data_size+tag_size-1:0] net_tx_data,
  output logic                          host_rx_valid,
  input  logic                          host_rx_ready,
  output logic [data_size-1:0]          host_rx_data,
  output logic                          tx_full,
  output logic [cnt_size-1:0]           tx_drop_cnt,
  output logic [cnt_size-1:0]           rx_mismatch_cnt,
  output logic [cnt_size-1:0]           overflow_cnt
);
  logic                 w_is_tx;
  logic                 w_is_rx;
  logic                 w_is_clr;
  logic                 w_push;
  logic                 w_pop;
  logic                 w_empty;
  logic                 w_full;
  logic                 w_rx_load;
  logic                 r_rx_valid;
  logic [data_size-1:0] r_rx_data;

  // Opcode decode.
  always_comb begin
    w_is_tx  = 1'b0;
    w_is_rx  = 1'b0;
    w_is_clr = 1'b0;
    case (opcode_in)
      OP_TX:   w_is_tx  = 1'b1;
      OP_RX:   w_is_rx  = 1'b1;
      OP_CLR:  w_is_clr = 1'b1;
      default: ;
    endcase
  end

  // ---------------- TX path ----------------
  assign w_push       = w_is_tx && !soft_error_in;
  assign w_pop        = !w_empty && net_tx_ready;
  assign net_tx_valid = !w_empty;
  assign tx_full      = w_full;

  stage_4_tx_fifo #(
    .WIDTH(data_size + tag_size),
    .DEPTH(fifo_depth)
  ) u_tx_fifo (
    .clk    (clk),
    .reset  (reset),
    .i_push (w_push),
    .i_pop  (w_pop),
    .i_data (tx_word_in),
    .o_data (net_tx_data),
    .o_full (w_full),
    .o_empty(w_empty)
  );

  // ---------------- RX path ----------------
  // Load when the register is free now or is being handed to the host.
  assign w_rx_load = w_is_rx && tag_match_in && (!r_rx_valid || host_rx_ready);

  // One-entry RX register; held data stays put until accepted.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_rx_valid <= 1'b0;
      r_rx_data  <= '0;
    end else if (w_rx_load) begin
      r_rx_valid <= 1'b1;
      r_rx_data  <= rx_data_in;
    end else if (r_rx_valid && host_rx_ready) begin
      r_rx_valid <= 1'b0;
    end
  end

  assign host_rx_valid = r_rx_valid;
  assign host_rx_data  = r_rx_data;

  // ---------------- Statistics ----------------
`ifdef STAGE_4_STATS_EN
  logic                w_drop_ev;
  logic                w_mism_ev;
  logic                w_ovf_ev;
  logic [cnt_size-1:0] r_drop_cnt;
  logic [cnt_size-1:0] r_mism_cnt;
  logic [cnt_size-1:0] r_ovf_cnt;

  function automatic logic [cnt_size-1:0] f_sat_inc(input logic [cnt_size-1:0] v);
    return (v == {cnt_size{1'b1}}) ? v : v + {{(cnt_size-1){1'b0}}, 1'b1};
  endfunction

  assign w_drop_ev = w_is_tx && soft_error_in;
  assign w_mism_ev = w_is_rx && !tag_match_in;
  // Overflow: clean TX into a full FIFO with no pop, or verified RX that
  // finds the register occupied and not being consumed.
  assign w_ovf_ev  = (w_push && w_full && !w_pop) ||
                     (w_is_rx && tag_match_in && !w_rx_load);

  // Saturating counters; CLR wins over any event.
  always_ff @(posedge clk) begin
    if (reset || w_is_clr) begin
      r_drop_cnt <= '0;
      r_mism_cnt <= '0;
      r_ovf_cnt  <= '0;
    end else begin
      if (w_drop_ev) r_drop_cnt <= f_sat_inc(r_drop_cnt);
      if (w_mism_ev) r_mism_cnt <= f_sat_inc(r_mism_cnt);
      if (w_ovf_ev)  r_ovf_cnt  <= f_sat_inc(r_ovf_cnt);
    end
  end

  assign tx_drop_cnt     = r_drop_cnt;
  assign rx_mismatch_cnt = r_mism_cnt;
  assign overflow_cnt    = r_ovf_cnt;
`else
  logic w_unused_clr;
  assign w_unused_clr    = w_is_clr;
  assign tx_drop_cnt     = {cnt_size{1'b0}};
  assign rx_mismatch_cnt = {cnt_size{1'b0}};
  assign overflow_cnt    = {cnt_size{1'b0}};
`endif
endmodule
